// File: rtl/lock_pkg.sv
// Shared types and default key constants for the unlock controller.
// Key word 0 is the least-significant word of the key and is entered first.
package lock_pkg;

  localparam int DEF_KEY_W       = 8;
  localparam int DEF_KEY_LEN     = 4;
  localparam int DEF_KEY_BITS    = DEF_KEY_W * DEF_KEY_LEN;
  localparam logic [DEF_KEY_BITS-1:0] DEF_KEY_VAL = 32'hA5_3C_0F_96;
  localparam int DEF_MAX_FAIL    = 3;
  localparam int DEF_LOCKOUT_CYC = 64;
  localparam int DEF_UNLOCK_CYC  = 256;

  typedef enum logic [1:0] {
    S_LOCKED,
    S_ENTRY,
    S_UNLOCKED,
    S_LOCKOUT
  } lock_state_t;

  typedef logic [DEF_KEY_W-1:0] key_word_t;

  function automatic key_word_t key_word(input logic [DEF_KEY_BITS-1:0] key,
                                         input int unsigned i);
    logic [DEF_KEY_BITS-1:0] w_shift;
    w_shift = key >> (i * DEF_KEY_W);
    return w_shift[DEF_KEY_W-1:0];
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; o_done is high while enabled and the count has reached zero.
// The count holds at zero instead of wrapping.
module lock_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_done
);

  logic [W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_done = i_en && (r_count == '0);

endmodule

// File: rtl/unlock_key_fsm.sv
// Serial key checker driving the unlock input of a lock-on-reset register stage.
// Adds an attempt limit with timed lockout and an inactivity auto-relock.
module unlock_key_fsm
  import lock_pkg::*;
#(
  parameter int KEY_W       = DEF_KEY_W,
  parameter int KEY_LEN     = DEF_KEY_LEN,
  parameter logic [KEY_W*KEY_LEN-1:0] KEY_VAL = DEF_KEY_VAL,
  parameter int MAX_FAIL    = DEF_MAX_FAIL,
  parameter int LOCKOUT_CYC = DEF_LOCKOUT_CYC,
  parameter int UNLOCK_CYC  = DEF_UNLOCK_CYC,
  localparam int FC_W       = $clog2(MAX_FAIL + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_in,
  input  logic             relock,
  output logic             unlock,
  output logic             lockout,
  output logic [FC_W-1:0]  fail_cnt,
  output logic             busy
);

  localparam int IDX_W = $clog2(KEY_LEN);
  localparam int UT_W  = $clog2(UNLOCK_CYC);
  localparam int LT_W  = $clog2(LOCKOUT_CYC);

  lock_state_t     r_state;
  logic [IDX_W-1:0] r_idx;
  logic            r_mismatch;
  logic [FC_W-1:0] r_fail_cnt;
  logic            r_unlock;
  logic            r_lockout;

  logic            w_word_bad;
  logic            w_last;
  logic            w_pass;
  logic            w_final;
  logic [FC_W-1:0] w_fail_next;
  logic            w_lockout_now;
  logic            w_ut_load;
  logic            w_ut_done;
  logic            w_lt_load;
  logic            w_lt_done;

  // r_idx is zero in LOCKED, so the same compare serves the first word.
  assign w_word_bad  = (key_in != key_word(KEY_VAL, 32'(r_idx)));
  assign w_last      = (r_idx == IDX_W'(KEY_LEN - 1));
  assign w_pass      = !(r_mismatch || w_word_bad);
  assign w_final     = (r_state == S_ENTRY) && key_valid && !relock && w_last;
  assign w_fail_next = (r_fail_cnt < FC_W'(MAX_FAIL)) ? r_fail_cnt + FC_W'(1) : r_fail_cnt;
  assign w_lockout_now = (w_fail_next == FC_W'(MAX_FAIL));

  assign w_ut_load = (w_final && w_pass) || ((r_state == S_UNLOCKED) && key_valid);
  assign w_lt_load = w_final && !w_pass && w_lockout_now;

  lock_timer #(.W(UT_W)) u_unlock_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_ut_load),
    .i_load_val (UT_W'(UNLOCK_CYC - 1)),
    .i_en       (r_state == S_UNLOCKED),
    .o_done     (w_ut_done)
  );

  lock_timer #(.W(LT_W)) u_lockout_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_lt_load),
    .i_load_val (LT_W'(LOCKOUT_CYC - 1)),
    .i_en       (r_state == S_LOCKOUT),
    .o_done     (w_lt_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_LOCKED;
      r_idx      <= '0;
      r_mismatch <= 1'b0;
      r_fail_cnt <= '0;
      r_unlock   <= 1'b0;
      r_lockout  <= 1'b0;
    end else begin
      case (r_state)
        S_LOCKED: begin
          if (key_valid && !relock) begin
            r_state    <= S_ENTRY;
            r_idx      <= IDX_W'(1);
            r_mismatch <= w_word_bad;
          end
        end
        S_ENTRY: begin
          if (relock) begin
            r_state    <= S_LOCKED;
            r_idx      <= '0;
            r_mismatch <= 1'b0;
          end else if (key_valid) begin
            if (w_last) begin
              r_idx      <= '0;
              r_mismatch <= 1'b0;
              if (w_pass) begin
                r_state    <= S_UNLOCKED;
                r_unlock   <= 1'b1;
                r_fail_cnt <= '0;
              end else begin
                r_fail_cnt <= w_fail_next;
                if (w_lockout_now) begin
                  r_state   <= S_LOCKOUT;
                  r_lockout <= 1'b1;
                end else begin
                  r_state <= S_LOCKED;
                end
              end
            end else begin
              r_idx      <= r_idx + IDX_W'(1);
              r_mismatch <= r_mismatch || w_word_bad;
            end
          end
        end
        S_UNLOCKED: begin
          // Activity restarts the timeout even on the cycle it would expire.
          if (relock || (w_ut_done && !key_valid)) begin
            r_state  <= S_LOCKED;
            r_unlock <= 1'b0;
          end
        end
        S_LOCKOUT: begin
          if (w_lt_done) begin
            r_state    <= S_LOCKED;
            r_lockout  <= 1'b0;
            r_fail_cnt <= '0;
          end
        end
        default: begin
          r_state  <= S_LOCKED;
          r_unlock <= 1'b0;
        end
      endcase
    end
  end

  assign unlock   = r_unlock;
  assign lockout  = r_lockout;
  assign fail_cnt = r_fail_cnt;
  assign busy     = (r_state == S_ENTRY);

endmodule

// File: tb/tb_unlock_key_fsm.sv
// Self-checking bench for unlock_key_fsm: directed scenarios plus random traffic
// compared against a queue-based behavioural model of the unlock rules.
module tb_unlock_key_fsm;

  localparam logic [31:0] KV = 32'hA5_3C_0F_96;
  localparam int KEY_LEN     = 4;
  localparam int MAX_FAIL    = 3;
  localparam int LOCKOUT_CYC = 64;
  localparam int UNLOCK_CYC  = 256;

  logic       clk;
  logic       reset;
  logic       key_valid;
  logic [7:0] key_in;
  logic       relock;
  logic       unlock;
  logic       lockout;
  logic [1:0] fail_cnt;
  logic       busy;

  int errors = 0;
  int checks = 0;

  unlock_key_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_in    (key_in),
    .relock    (relock),
    .unlock    (unlock),
    .lockout   (lockout),
    .fail_cnt  (fail_cnt),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: words collected so far, whole-key compare at the end.
  logic [7:0] m_entry[$];
  bit         m_unlocked;
  int         m_idle;
  int         m_lock_left;
  int         m_fails;

  task automatic model_reset();
    m_entry.delete();
    m_unlocked  = 1'b0;
    m_idle      = 0;
    m_lock_left = 0;
    m_fails     = 0;
  endtask

  task automatic model_step(input bit kv, input logic [7:0] k, input bit rl);
    logic [31:0] entered;
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (m_unlocked) begin
      if (rl) m_unlocked = 1'b0;
      else if (kv) m_idle = 0;
      else if (m_idle == UNLOCK_CYC - 1) m_unlocked = 1'b0;
      else m_idle++;
    end else if (rl) begin
      m_entry.delete();
    end else if (kv) begin
      m_entry.push_back(k);
      if (m_entry.size() == KEY_LEN) begin
        entered = '0;
        for (int i = 0; i < KEY_LEN; i++) entered = entered | (32'(m_entry[i]) << (8 * i));
        m_entry.delete();
        if (entered == KV) begin
          m_unlocked = 1'b1;
          m_idle     = 0;
          m_fails    = 0;
        end else begin
          if (m_fails < MAX_FAIL) m_fails++;
          if (m_fails == MAX_FAIL) m_lock_left = LOCKOUT_CYC;
        end
      end
    end
  endtask

  function automatic logic [4:0] exp_vec();
    return {m_unlocked, (m_lock_left > 0), 2'(m_fails), (m_entry.size() != 0)};
  endfunction

  wire [4:0] w_dut = {unlock, lockout, fail_cnt, busy};

  // One clock: drive inputs, take the edge, advance the model, settle 1 ns past the edge.
  task automatic step(input bit kv, input logic [7:0] k, input bit rl);
    key_valid = kv;
    key_in    = k;
    relock    = rl;
    @(posedge clk);
    model_step(kv, k, rl);
    #1;
    key_valid = 1'b0;
    relock    = 1'b0;
  endtask

  // Word 0 is the least-significant byte of the key and goes in first.
  task automatic enter_key(input logic [31:0] val, input int gap);
    for (int i = 0; i < KEY_LEN; i++) begin
      step(1'b1, val[8*i +: 8], 1'b0);
      if (i != KEY_LEN - 1) repeat (gap) step(1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; key_valid = 1'b0; key_in = 8'h00; relock = 1'b0;
    model_reset();
    #12;
    if (w_dut !== 5'b00000) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", w_dut, 5'b00000);
    end
    checks++;
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unlock();
    enter_key(KV, 0);
    if (w_dut !== 5'b10000 || w_dut !== exp_vec()) begin
      errors++;
      $display("FAIL unlock_after_key got=%b exp=%b", w_dut, 5'b10000);
    end
    checks++;
    step(1'b0, 8'h00, 1'b1);
    if (w_dut !== 5'b00000) begin
      errors++;
      $display("FAIL relock_pulse got=%b exp=%b", w_dut, 5'b00000);
    end
    checks++;
  endtask

  task automatic test_bad_key();
    enter_key(KV ^ 32'h0100_0000, 0);
    if (w_dut !== 5'b00010 || w_dut !== exp_vec()) begin
      errors++;
      $display("FAIL bad_last_word got=%b exp=%b", w_dut, 5'b00010);
    end
    checks++;
    for (int i = 0; i < KEY_LEN; i++) begin
      step(1'b1, (i == 0) ? (KV[7:0] ^ 8'h01) : KV[8*i +: 8], 1'b0);
      if (w_dut !== exp_vec()) begin
        errors++;
        $display("FAIL bad_first_word word=%0d got=%b exp=%b", i, w_dut, exp_vec());
      end
      checks++;
    end
    if (fail_cnt !== 2'd2) begin
      errors++;
      $display("FAIL bad_first_count got=%0d exp=2", fail_cnt);
    end
    checks++;
  endtask

  task automatic test_lockout();
    int high;
    enter_key(KV, 0);
    step(1'b0, 8'h00, 1'b1);
    repeat (MAX_FAIL) enter_key(KV ^ 32'h0000_5500, 1);
    high = (lockout === 1'b1) ? 1 : 0;
    for (int c = 0; c < LOCKOUT_CYC + 8; c++) begin
      step(1'b1, KV[8*(c % KEY_LEN) +: 8], 1'b0);
      if (w_dut !== exp_vec()) begin
        errors++;
        $display("FAIL lockout_cycle c=%0d got=%b exp=%b", c, w_dut, exp_vec());
      end
      checks++;
      if (lockout === 1'b1) high++;
      if (m_lock_left == 0) break;
    end
    if (high !== LOCKOUT_CYC) begin
      errors++;
      $display("FAIL lockout_length got=%0d exp=%0d", high, LOCKOUT_CYC);
    end
    checks++;
    enter_key(KV, 0);
    if (w_dut !== 5'b10000) begin
      errors++;
      $display("FAIL unlock_after_lockout got=%b exp=%b", w_dut, 5'b10000);
    end
    checks++;
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_timeout();
    int drop_at;
    enter_key(KV, 0);
    drop_at = -1;
    for (int i = 1; i < 600; i++) begin
      step(i == 200, 8'h5A, 1'b0);
      if (w_dut !== exp_vec()) begin
        errors++;
        $display("FAIL timeout_cycle i=%0d got=%b exp=%b", i, w_dut, exp_vec());
      end
      checks++;
      if (unlock !== 1'b1) begin
        drop_at = i;
        break;
      end
    end
    if (drop_at !== 200 + UNLOCK_CYC) begin
      errors++;
      $display("FAIL timeout_restart got=%0d exp=%0d", drop_at, 200 + UNLOCK_CYC);
    end
    checks++;
  endtask

  task automatic async_reset_pulse(input string name);
    #2 reset = 1'b1;
    #1;
    model_reset();
    if (w_dut !== 5'b00000) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, w_dut, 5'b00000);
    end
    checks++;
    #2 reset = 1'b0;
  endtask

  task automatic test_async_reset();
    step(1'b1, KV[7:0], 1'b0);
    step(1'b1, KV[15:8], 1'b0);
    async_reset_pulse("reset_mid_entry");
    step(1'b1, KV[23:16], 1'b0);
    step(1'b1, KV[31:24], 1'b0);
    if (unlock !== 1'b0 || w_dut !== exp_vec()) begin
      errors++;
      $display("FAIL partial_after_reset got=%b exp=%b", w_dut, exp_vec());
    end
    checks++;
    step(1'b0, 8'h00, 1'b1);
    enter_key(KV, 0);
    async_reset_pulse("reset_mid_unlocked");
    enter_key(KV, 0);
    if (w_dut !== 5'b10000) begin
      errors++;
      $display("FAIL fresh_unlock got=%b exp=%b", w_dut, 5'b10000);
    end
    checks++;
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_relock_final();
    enter_key(KV ^ 32'h0000_0080, 0);
    for (int i = 0; i < KEY_LEN; i++) step(1'b1, KV[8*i +: 8], i == KEY_LEN - 1);
    if (w_dut !== 5'b00010 || w_dut !== exp_vec()) begin
      errors++;
      $display("FAIL relock_on_final got=%b exp=%b", w_dut, 5'b00010);
    end
    checks++;
    enter_key(KV, 5);
    if (w_dut !== 5'b10000 || w_dut !== exp_vec()) begin
      errors++;
      $display("FAIL gapped_entry got=%b exp=%b", w_dut, 5'b10000);
    end
    checks++;
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_random();
    bit         kv;
    bit         rl;
    logic [7:0] k;
    int         idx;
    for (int c = 0; c < 3000; c++) begin
      kv  = ($urandom_range(0, 1) == 1);
      rl  = ($urandom_range(0, 63) == 0);
      idx = m_entry.size();
      k   = ($urandom_range(0, 3) != 0) ? KV[8*idx +: 8] : 8'($urandom);
      step(kv, k, rl);
      if (w_dut !== exp_vec()) begin
        errors++;
        $display("FAIL random c=%0d got=%b exp=%b", c, w_dut, exp_vec());
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_bad_key();
    test_lockout();
    test_timeout();
    test_async_reset();
    test_relock_final();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
